// File: rtl/shoot_timer_pkg.sv
// rtl/shoot_timer_pkg.sv - shared FSM states, register map and STATUS bit layout for shoot_timer_mc
package shoot_timer_pkg;

   typedef enum logic [1:0] {IDLE, FIRE, HOLDOFF} state_t;

   localparam logic [2:0] A_CTRL    = 3'd0;
   localparam logic [2:0] A_STATUS  = 3'd1;
   localparam logic [2:0] A_HOLDOFF = 3'd2;
   localparam logic [2:0] A_CLR     = 3'd3;

   localparam int ST_BUSY   = 4;
   localparam int ST_REJECT = 5;
   localparam int ST_ARM    = 6;
   localparam int ST_CLAMP  = 7;

   localparam int MAX_PULSE = 100;

endpackage

// File: rtl/shoot_down_counter.sv
// rtl/shoot_down_counter.sv - loadable down-counter with zero flag, shared by fire and holdoff timing
module shoot_down_counter #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count,
   output logic         zero
);

   assign zero = (count == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (en && !zero)
         count <= count - W'(1);
   end

endmodule

// File: rtl/shoot_timer_mc.sv
// rtl/shoot_timer_mc.sv - multi-channel kicker pulse generator with holdoff and arm gate
// Optional pulse clamp to MAX_PULSE when SHOOT_TIMER_MAXCLAMP_EN is defined.
module shoot_timer_mc
   import shoot_timer_pkg::*;
#(
   parameter int               CNT_W       = 24,
   parameter int               NUM_CH      = 2,
   parameter logic [CNT_W-1:0] HOLDOFF_DEF = CNT_W'(50000)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        addr,
   input  logic [CNT_W-1:0]  wrdata,
   input  logic              wr_n,
   input  logic              rd_n,
   output logic [CNT_W-1:0]  rddata,
   output logic [NUM_CH-1:0] dout,
   output logic              busy
);

   state_t           state;
   logic             arm, reject, clamp_flag;
   logic [CNT_W-1:0] holdoff;
   logic [1:0]       active;

   logic [CNT_W-1:0] count, cnt_val, pulse_val, rd_val;
   logic             zero, last, cnt_load, cnt_en;
   logic             is_pulse, pulse_wr, arm_off_wr, nz, over_max;
   logic             go_fire, go_hold, go_idle, rej;
   logic [1:0]       ch;

   assign ch         = addr[1:0];
   assign is_pulse   = addr[2] && (int'(addr[1:0]) < NUM_CH);
   assign pulse_wr   = !wr_n && is_pulse;
   assign arm_off_wr = !wr_n && (addr == A_CTRL) && !wrdata[0];
   assign nz         = (wrdata != '0);
   assign last       = zero || (count == CNT_W'(1));

`ifdef SHOOT_TIMER_MAXCLAMP_EN
   assign over_max = (wrdata > CNT_W'(MAX_PULSE));
`else
   assign over_max = 1'b0;
`endif
   assign pulse_val = over_max ? CNT_W'(MAX_PULSE) : wrdata;

   // Bus writes are resolved before the terminal count, so a same-cycle write wins.
   always_comb begin
      go_fire = 1'b0;
      go_hold = 1'b0;
      go_idle = 1'b0;
      rej     = 1'b0;
      case (state)
         IDLE: if (pulse_wr && nz) begin
            if (arm) go_fire = 1'b1;
            else     rej     = 1'b1;
         end
         FIRE: if (pulse_wr && ch == active) begin
            if (nz) go_fire = 1'b1;
            else    go_hold = 1'b1;
         end else begin
            if (pulse_wr && nz)        rej     = 1'b1;
            if (arm_off_wr || last)    go_hold = 1'b1;
         end
         HOLDOFF: begin
            if (pulse_wr && nz) rej     = 1'b1;
            if (last)           go_idle = 1'b1;
         end
         default: ;
      endcase
   end

   assign cnt_load = go_fire || go_hold;
   assign cnt_val  = go_fire ? pulse_val : holdoff;
   assign cnt_en   = (state != IDLE);

   shoot_down_counter #(.W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .en       (cnt_en),
      .load_val (cnt_val),
      .count    (count),
      .zero     (zero)
   );

   always_comb begin
      rd_val = '0;
      case (addr)
         A_CTRL:    rd_val[0] = arm;
         A_STATUS: begin
            rd_val[NUM_CH-1:0] = dout;
            rd_val[ST_BUSY]    = busy;
            rd_val[ST_REJECT]  = reject;
            rd_val[ST_ARM]     = arm;
            rd_val[ST_CLAMP]   = clamp_flag;
         end
         A_HOLDOFF: rd_val = holdoff;
         default:   if (is_pulse && state == FIRE && ch == active) rd_val = count;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         arm        <= 1'b0;
         reject     <= 1'b0;
         clamp_flag <= 1'b0;
         holdoff    <= HOLDOFF_DEF;
         active     <= '0;
         dout       <= '0;
         busy       <= 1'b0;
         rddata     <= '0;
      end else begin
         if (!wr_n && addr == A_CTRL)    arm     <= wrdata[0];
         if (!wr_n && addr == A_HOLDOFF) holdoff <= wrdata;
         if (!wr_n && addr == A_CLR) begin
            reject     <= 1'b0;
            clamp_flag <= 1'b0;
         end else begin
            if (rej)                 reject     <= 1'b1;
            if (go_fire && over_max) clamp_flag <= 1'b1;
         end
         if (go_fire) begin
            state  <= FIRE;
            active <= ch;
            dout   <= NUM_CH'(1) << ch;
            busy   <= 1'b1;
         end else if (go_hold) begin
            dout <= '0;
            if (holdoff == '0) begin
               state <= IDLE;
               busy  <= 1'b0;
            end else begin
               state <= HOLDOFF;
               busy  <= 1'b1;
            end
         end else if (go_idle) begin
            state <= IDLE;
            busy  <= 1'b0;
         end
         if (!rd_n) rddata <= rd_val;
      end
   end

endmodule

// File: tb/tb_shoot_timer_mc.sv
// tb/tb_shoot_timer_mc.sv - scoreboard bench for shoot_timer_mc (pulse, busy and read-back checks)
module tb_shoot_timer_mc;
   import shoot_timer_pkg::MAX_PULSE;

`ifdef SHOOT_TIMER_MAXCLAMP_EN
   localparam bit CLAMP_ON = 1'b1;
`else
   localparam bit CLAMP_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  addr = '0;
   logic [23:0] wrdata = '0;
   logic        wr_n = 1'b1;
   logic        rd_n = 1'b1;
   logic [23:0] rddata;
   logic [1:0]  dout;
   logic        busy;

   shoot_timer_mc dut (
      .clk    (clk),
      .reset  (reset),
      .addr   (addr),
      .wrdata (wrdata),
      .wr_n   (wr_n),
      .rd_n   (rd_n),
      .rddata (rddata),
      .dout   (dout),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   typedef struct {int ch; int len;} pulse_t;
   typedef struct {string tag; logic [31:0] val;} rd_t;

   pulse_t pulse_q[$];
   int     busy_q[$];
   rd_t    rd_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] st(input logic [1:0] d, input bit b, input bit r,
                                      input bit a, input bit c);
      return {24'd0, c, a, r, b, 2'b00, d};
   endfunction

   task automatic bus_wr(input logic [2:0] a, input int d);
      addr = a; wrdata = d[23:0]; wr_n = 1'b0;
      @(negedge clk);
      wr_n = 1'b1;
   endtask

   task automatic bus_rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
      rd_t r;
      r.tag = tag; r.val = exp;
      rd_q.push_back(r);
      addr = a; rd_n = 1'b0;
      @(negedge clk);
      rd_n = 1'b1;
   endtask

   task automatic expect_shot(input int ch, input int len, input int bsy);
      pulse_t p;
      p.ch = ch; p.len = len;
      pulse_q.push_back(p);
      busy_q.push_back(bsy);
   endtask

   bit rd_seen = 1'b0;
   always @(posedge clk) rd_seen = reset && !rd_n;

   int run_len = 0, run_ch = 0, busy_len = 0;

   always @(negedge clk) begin
      if (!reset) begin
         run_len = 0; busy_len = 0; rd_seen = 1'b0;
      end else begin
         if (rd_seen) begin
            rd_t r;
            rd_seen = 1'b0;
            if (rd_q.size() == 0) check("rd_unexpected", {8'd0, rddata}, 32'd0);
            else begin
               r = rd_q.pop_front();
               check(r.tag, {8'd0, rddata}, r.val);
            end
         end
         if (dout != 2'b00) begin
            check("dout_onehot", {31'd0, $onehot(dout)}, 32'd1);
            run_len++;
            run_ch = dout[1] ? 1 : 0;
         end else if (run_len > 0) begin
            if (pulse_q.size() == 0) check("pulse_unexpected", run_len, 0);
            else begin
               pulse_t p;
               p = pulse_q.pop_front();
               check("pulse_ch", run_ch, p.ch);
               check("pulse_len", run_len, p.len);
            end
            run_len = 0;
         end
         if (busy) busy_len++;
         else if (busy_len > 0) begin
            if (busy_q.size() == 0) check("busy_unexpected", busy_len, 0);
            else check("busy_len", busy_len, busy_q.pop_front());
            busy_len = 0;
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_dout", {30'd0, dout}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rddata", {8'd0, rddata}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      bus_rd("ctrl_rst", 3'd0, 32'd0);
      bus_rd("holdoff_rst", 3'd2, 32'd50000);

      // basic shot, holdoff 10
      bus_wr(3'd0, 1);
      bus_wr(3'd2, 10);
      bus_rd("ctrl_arm", 3'd0, 32'd1);
      bus_rd("holdoff_10", 3'd2, 32'd10);
      expect_shot(0, 5, 15);
      bus_wr(3'd4, 5);
      bus_rd("status_fire", 3'd1, st(2'b01, 1, 0, 1, 0));
      bus_rd("pulse0_remain", 3'd4, 32'd4);
      bus_rd("pulse1_idle_ch", 3'd5, 32'd0);
      repeat (30) @(negedge clk);
      bus_rd("status_after", 3'd1, st(2'b00, 0, 0, 1, 0));

      // disarmed shot rejected, CLR clears flag
      bus_wr(3'd0, 0);
      bus_wr(3'd5, 5);
      bus_rd("status_rej_disarm", 3'd1, st(2'b00, 0, 1, 0, 0));
      bus_wr(3'd3, 0);
      bus_rd("status_clr", 3'd1, st(2'b00, 0, 0, 0, 0));

      // other-channel reject during fire, then same-channel reload
      bus_wr(3'd0, 1);
      expect_shot(0, 22, 32);
      bus_wr(3'd4, 50);
      bus_wr(3'd5, 3);
      bus_wr(3'd4, 20);
      bus_rd("status_rej_fire", 3'd1, st(2'b01, 1, 1, 1, 0));
      repeat (45) @(negedge clk);
      bus_wr(3'd3, 0);

      // write during holdoff is rejected
      expect_shot(0, 4, 14);
      bus_wr(3'd4, 4);
      repeat (4) @(negedge clk);
      bus_wr(3'd4, 4);
      bus_rd("status_rej_hold", 3'd1, st(2'b00, 1, 1, 1, 0));
      repeat (20) @(negedge clk);
      bus_wr(3'd3, 0);

      // abort by disarm, then abort by zero write to active channel
      expect_shot(1, 2, 12);
      bus_wr(3'd5, 10);
      @(negedge clk);
      bus_wr(3'd0, 0);
      bus_wr(3'd0, 1);
      repeat (20) @(negedge clk);
      expect_shot(0, 1, 11);
      bus_wr(3'd4, 10);
      bus_wr(3'd4, 0);
      repeat (20) @(negedge clk);

      // zero holdoff: back-to-back shots, including length 1
      bus_wr(3'd2, 0);
      expect_shot(1, 3, 3);
      bus_wr(3'd5, 3);
      repeat (4) @(negedge clk);
      expect_shot(0, 2, 2);
      bus_wr(3'd4, 2);
      repeat (4) @(negedge clk);
      expect_shot(1, 1, 1);
      bus_wr(3'd5, 1);
      repeat (3) @(negedge clk);
      bus_rd("status_b2b", 3'd1, st(2'b00, 0, 0, 1, 0));

      // oversize pulse: clamped only when the clamp is built in
      bus_wr(3'd2, 5);
      expect_shot(0, CLAMP_ON ? MAX_PULSE : MAX_PULSE + 1,
                 (CLAMP_ON ? MAX_PULSE : MAX_PULSE + 1) + 5);
      bus_wr(3'd4, MAX_PULSE + 1);
      repeat (MAX_PULSE + 20) @(negedge clk);
      bus_rd("status_clamp", 3'd1, st(2'b00, 0, 0, 1, CLAMP_ON));
      bus_wr(3'd3, 0);
      bus_rd("status_clamp_clr", 3'd1, st(2'b00, 0, 0, 1, 0));

      // reset mid-fire
      bus_wr(3'd4, 1000);
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("rst_async_dout", {30'd0, dout}, 32'd0);
      check("rst_async_busy", {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      bus_rd("status_post_rst", 3'd1, 32'd0);
      bus_rd("holdoff_post_rst", 3'd2, 32'd50000);
      bus_rd("ctrl_post_rst", 3'd0, 32'd0);

      repeat (10) @(negedge clk);
      check("pulse_q_drained", pulse_q.size(), 0);
      check("busy_q_drained", busy_q.size(), 0);
      check("rd_q_drained", rd_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/shoot_timer_mc.md
# shoot_timer_mc

Multi-channel kicker pulse generator for the robot's shooting path: the CPU writes a pulse length over the register bus and the block drives exactly one solenoid output (flat kick or chip) high for that many clock cycles. It then enforces a programmable recharge holdoff during which all further shots are rejected. It sits between the bus slave decoder and the kicker driver pins. It supersedes the single-channel timer with parametrised width and channel count, an arm gate, mutual exclusion between channels and a readable status.

## Interface
- CNT_W, 24: width of pulse and holdoff counters and of the bus data.
- NUM_CH, 2: number of shoot channels, 1..4 (ch0 = flat, ch1 = chip).
- HOLDOFF_DEF, 24'd50000: reset value of the HOLDOFF register.
- clk  in  1  single system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  3  register address.
- wrdata  in  CNT_W  write data.
- wr_n  in  1  active-low write strobe, sampled on the clk edge.
- rd_n  in  1  active-low read strobe, sampled on the clk edge.
- rddata  out  CNT_W  registered read data.
- dout  out  NUM_CH  solenoid drive, at most one bit high at any time.
- busy  out  1  high in FIRE or HOLDOFF.

## Operation
- Register map:
  - 0 CTRL: bit0 ARM, read/write.
  - 1 STATUS: read only, see below.
  - 2 HOLDOFF: read/write, length in cycles.
  - 3 CLR: a write of any value clears the reject flag.
  - 4+ch PULSE[ch]: a write requests a shot; a read returns the remaining count if ch is the active channel, else 0.
  - Unmapped addresses and ch >= NUM_CH: writes are ignored, reads return 0.
- STATUS bits: [NUM_CH-1:0] = dout; bit 4 = busy; bit 5 = sticky reject; bit 6 = ARM; all other bits 0.
- Single FSM with one down-counter and an active-channel index:
  - IDLE: a PULSE[ch] write with N != 0 and ARM = 1 goes to FIRE, loads N, active = ch.
  - FIRE: dout[active] = 1. The counter decrements each cycle. When it reaches 0, go to HOLDOFF and load the HOLDOFF value; if HOLDOFF = 0, go straight to IDLE.
  - HOLDOFF: the counter decrements; at 0, go to IDLE.
- Rejects: a PULSE write with N != 0 sets reject and changes no other state if any of these holds:
  - ARM = 0;
  - state is HOLDOFF;
  - state is FIRE and ch differs from active.
- A PULSE write with N = 0 in IDLE is ignored and does not set reject.
- PULSE write to the active channel during FIRE: N != 0 reloads the counter with N; N = 0 aborts to HOLDOFF.
- Writing ARM = 0 during FIRE aborts to HOLDOFF. Writing ARM = 0 during HOLDOFF has no effect on the holdoff.
- HOLDOFF register writes take effect at the next HOLDOFF entry.

## Timing
- Reset values:
  - state IDLE, counter 0, ARM 0, reject 0;
  - HOLDOFF = HOLDOFF_DEF;
  - dout 0, busy 0, rddata 0.
- dout and busy are registered. A PULSE write at edge k makes dout[ch] high for cycles k+1 … k+N, exactly N cycles.
- Holdoff occupies exactly H cycles after the fire ends. busy is high for N+H cycles in total.
- Abort at edge k: dout is low from cycle k+1.
- Read latency is 1 cycle: rddata updates on the edge where rd_n is sampled low and holds its value otherwise.
- A write in the same cycle as the counter reaching its terminal value takes priority over the terminal transition.
- Asserting reset mid-fire drops dout immediately, independent of clk.

## Configuration
- SHOOT_TIMER_MAXCLAMP_EN, when defined:
  - PULSE values above the constant MAX_PULSE (from the package) are clamped to MAX_PULSE;
  - the clamp sets status bit 7 (sticky, cleared by a CLR write).
- When undefined: pulse values are used unmodified and bit 7 reads 0.

## Structure
- Package shoot_timer_pkg: FSM state enum (IDLE, FIRE, HOLDOFF), register address constants, STATUS bit positions, MAX_PULSE.
- Sub-module shoot_down_counter: CNT_W-bit loadable down-counter with load, enable and zero flag. It is instantiated once and shared by the FIRE and HOLDOFF states.

## Test plan
- ARM = 1, HOLDOFF = 10, write PULSE[0] = 5 -> dout = 01 for exactly 5 cycles, busy for 15 cycles, then IDLE; reject = 0.
- ARM = 0, write PULSE[1] = 5 -> dout stays 00 and STATUS bit 5 = 1; a write to CLR then gives bit 5 = 0.
- During FIRE on ch0, write PULSE[1] = 3 -> reject set and ch0 unaffected. Write PULSE[0] = 20 at the same point -> ch0 pulse restarts and lasts 20 cycles from that write.
- During HOLDOFF, write PULSE[0] = 4 -> reject set, no dout. With HOLDOFF = 0, back-to-back shots on ch1 and then ch0 succeed.
- Assert reset mid-fire with pulse 1000 -> dout = 0 immediately; after release, STATUS reads 0, HOLDOFF reads 50000, ARM reads 0.
- With SHOOT_TIMER_MAXCLAMP_EN defined, write PULSE[0] = MAX_PULSE + 1 -> dout high for exactly MAX_PULSE cycles and status bit 7 = 1.
